vregfile: RTL and testbench

//  Parametrised vector register file for the vector datapath: NUM_REGS x VLEN bits, two read ports plus a dedicated v0 mask read.
//  Has one byte-masked write port with same-cycle write-through bypass to all read ports.

---
 rtl/vregfile.sv | 141 ++++++++++++++
 tb/tb_vregfile.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vregfile.sv
// Vector register file: 2 read ports + v0 mask, byte-masked write with bypass,
// busy scoreboard and a one-register-per-cycle bulk-clear sequencer.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   vs1_addr_i/vs2_addr_i           read addresses
//   vs1_data_o/vs2_data_o/v0_mask_o read data (combinational, bypassed)
//   vs1_busy_o/vs2_busy_o           registered busy bit of each read address
//   we_i/vd_addr_i/wdata_i/wbe_i    byte-masked write port
//   rsv_i/rsv_addr_i/rsv_err_o      reserve request and double-reserve error
//   busy_o                          full scoreboard
//   clr_i/ready_o/clr_done_o        bulk clear start, idle flag, done pulse
module vregfile #(
  parameter int VLEN     = 128,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int NB      = VLEN / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       vs1_addr_i,
  input  logic [AW-1:0]       vs2_addr_i,
  output logic [VLEN-1:0]     vs1_data_o,
  output logic [VLEN-1:0]     vs2_data_o,
  output logic [VLEN-1:0]     v0_mask_o,
  output logic                vs1_busy_o,
  output logic                vs2_busy_o,
  input  logic                we_i,
  input  logic [AW-1:0]       vd_addr_i,
  input  logic [VLEN-1:0]     wdata_i,
  input  logic [NB-1:0]       wbe_i,
  input  logic                rsv_i,
  input  logic [AW-1:0]       rsv_addr_i,
  output logic                rsv_err_o,
  output logic [NUM_REGS-1:0] busy_o,
  input  logic                clr_i,
  output logic                ready_o,
  output logic                clr_done_o
);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t state_q, state_d;

  logic [VLEN-1:0]     regs_q [NUM_REGS];
  logic [AW-1:0]       idx_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [VLEN-1:0]     wr_val;
  logic                wr_en;
  logic                rsv_en;
  logic                last_clr;
  logic                rsv_clash;

  function automatic logic [VLEN-1:0] merge(
    input logic [VLEN-1:0] old_v,
    input logic [VLEN-1:0] new_v,
    input logic [NB-1:0]   be
  );
    logic [VLEN-1:0] r;
    r = old_v;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  assign wr_en    = we_i && ready_o;
  assign rsv_en   = rsv_i && ready_o;
  assign last_clr = (state_q == ST_CLEAR) &&
                    (idx_q == AW'(NUM_REGS - 1));
  assign wr_val   = merge(regs_q[vd_addr_i], wdata_i, wbe_i);

  // A reserve only errors if the same cycle is not also releasing it.
  assign rsv_clash = rsv_en && busy_o[rsv_addr_i] &&
                     !(wr_en && (vd_addr_i == rsv_addr_i));

  assign vs1_data_o = (wr_en && vd_addr_i == vs1_addr_i) ?
                      wr_val : regs_q[vs1_addr_i];
  assign vs2_data_o = (wr_en && vd_addr_i == vs2_addr_i) ?
                      wr_val : regs_q[vs2_addr_i];
  assign v0_mask_o  = (wr_en && vd_addr_i == '0) ?
                      wr_val : regs_q[0];

  assign vs1_busy_o = busy_o[vs1_addr_i];
  assign vs2_busy_o = busy_o[vs2_addr_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == ST_IDLE:  if (clr_i)    state_d = ST_CLEAR;
      state_q == ST_CLEAR: if (last_clr) state_d = ST_IDLE;
      default: ;
    endcase
  end

  always_comb begin
    ready_o = (state_q == ST_IDLE);
  end

  // Release first, then reserve, so a same-cycle reserve wins.
  always_comb begin
    busy_d = busy_o;
    if (wr_en)  busy_d[vd_addr_i]  = 1'b0;
    if (rsv_en) busy_d[rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      regs_q[idx_q] <= '0;
    end else if (wr_en) begin
      regs_q[vd_addr_i] <= wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o     <= '0;
      idx_q      <= '0;
      rsv_err_o  <= 1'b0;
      clr_done_o <= 1'b0;
    end else begin
      rsv_err_o  <= rsv_clash;
      clr_done_o <= last_clr;
      // Wraps to 0 on the last register.
      if (state_q == ST_CLEAR) idx_q <= idx_q + AW'(1);
      if (last_clr)     busy_o <= '0;
      else if (ready_o) busy_o <= busy_d;
    end
  end

endmodule

// File: tb/tb_vregfile.sv
// Testbench for vregfile: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_vregfile;
  localparam int VLEN = 128;
  localparam int NR   = 32;
  localparam int AW   = 5;
  localparam int NB   = VLEN / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   vs1_addr, vs2_addr, vd_addr, rsv_addr;
  logic [VLEN-1:0] vs1_data, vs2_data, v0_mask, wdata;
  logic            vs1_busy, vs2_busy, we, rsv, rsv_err, clr;
  logic            ready, clr_done;
  logic [NB-1:0]   wbe;
  logic [NR-1:0]   busy;

  vregfile #(.VLEN(VLEN), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .vs1_addr_i(vs1_addr), .vs2_addr_i(vs2_addr),
    .vs1_data_o(vs1_data), .vs2_data_o(vs2_data),
    .v0_mask_o(v0_mask),
    .vs1_busy_o(vs1_busy), .vs2_busy_o(vs2_busy),
    .we_i(we), .vd_addr_i(vd_addr), .wdata_i(wdata), .wbe_i(wbe),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr), .rsv_err_o(rsv_err),
    .busy_o(busy), .clr_i(clr), .ready_o(ready),
    .clr_done_o(clr_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [VLEN-1:0] m_regs [NR];
  logic [NR-1:0]   m_busy;
  bit              m_clr, m_err, m_done;
  int              m_cnt;

  task automatic chk(string tag, logic [VLEN-1:0] got,
                     logic [VLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] rnd_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [VLEN-1:0] m_read(logic [AW-1:0] a);
    logic [VLEN-1:0] v;
    v = m_regs[a];
    if (!m_clr && we && vd_addr == a) begin
      for (int k = 0; k < NB; k++)
        if (wbe[k]) v[8*k +: 8] = wdata[8*k +: 8];
    end
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_busy = '0; m_clr = 0; m_err = 0; m_done = 0; m_cnt = 0;
  endtask

  task automatic m_step();
    if (!m_clr) begin
      m_err = rsv && m_busy[rsv_addr] && !(we && vd_addr == rsv_addr);
      m_done = 0;
      if (we) begin
        m_regs[vd_addr] = m_read(vd_addr);
        m_busy[vd_addr] = 1'b0;
      end
      if (rsv) m_busy[rsv_addr] = 1'b1;
      if (clr) begin m_clr = 1; m_cnt = 0; end
    end else begin
      m_err = 0;
      m_regs[m_cnt] = '0;
      m_cnt++;
      m_done = (m_cnt == NR);
      if (m_done) begin m_clr = 0; m_busy = '0; end
    end
  endtask

  task automatic chk_outs();
    chk("vs1_data", vs1_data, m_read(vs1_addr));
    chk("vs2_data", vs2_data, m_read(vs2_addr));
    chk("v0_mask", v0_mask, m_read(AW'(0)));
    chk("vs1_busy", VLEN'(vs1_busy), VLEN'(m_busy[vs1_addr]));
    chk("vs2_busy", VLEN'(vs2_busy), VLEN'(m_busy[vs2_addr]));
    chk("busy", VLEN'(busy), VLEN'(m_busy));
    chk("ready", VLEN'(ready), VLEN'(!m_clr));
    chk("rsv_err", VLEN'(rsv_err), VLEN'(m_err));
    chk("clr_done", VLEN'(clr_done), VLEN'(m_done));
  endtask

  // Entered shortly after a posedge; leaves 1 time unit after the next.
  task automatic cyc();
    #3;
    chk_outs();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic set_idle();
    we = 0; rsv = 0; clr = 0; wbe = '0; wdata = '0;
    vd_addr = '0; rsv_addr = '0;
  endtask

  task automatic wr(logic [AW-1:0] a, logic [VLEN-1:0] d,
                    logic [NB-1:0] be);
    set_idle();
    we = 1; vd_addr = a; wdata = d; wbe = be;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, dn;
    set_idle();
    vs1_addr = '0; vs2_addr = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", VLEN'(ready), VLEN'(1));
    chk("rst_busy", VLEN'(busy), '0);
    chk("rst_v0", v0_mask, '0);
    rst_n = 1;

    // 1: plain write then read
    wr(5'd3, {16{8'hA5}}, '1);
    cyc();
    set_idle(); vs1_addr = 5'd3;
    #1 chk("t1_v3", vs1_data, {16{8'hA5}});

    // 2: byte mask
    wr(5'd5, {16{8'h11}}, '1);
    cyc();
    wr(5'd5, '1, 16'h00F0);
    cyc();
    set_idle(); vs1_addr = 5'd5;
    #1 chk("t2_mask", vs1_data,
           {{8{8'h11}}, {4{8'hFF}}, {4{8'h11}}});

    // 3: bypass on vs2 and v0
    wr(5'd7, {4{32'hDEADBEEF}}, '1); vs2_addr = 5'd7;
    #1 chk("t3_byp_vs2", vs2_data, {4{32'hDEADBEEF}});
    cyc();
    wr(5'd0, {4{32'h0BADF00D}}, '1);
    #1 chk("t3_byp_v0", v0_mask, {4{32'h0BADF00D}});
    cyc();

    // 4: scoreboard
    set_idle(); rsv = 1; rsv_addr = 5'd4; vs1_addr = 5'd4;
    cyc();
    set_idle();
    #1 chk("t4_busy4", VLEN'(busy[4]), VLEN'(1));
    chk("t4_vs1_busy", VLEN'(vs1_busy), VLEN'(1));
    rsv = 1; rsv_addr = 5'd4;
    cyc();
    set_idle();
    #1 chk("t4_err", VLEN'(rsv_err), VLEN'(1));
    wr(5'd4, '0, '0);
    cyc();
    set_idle();
    #1 chk("t4_rel", VLEN'(busy[4]), VLEN'(0));
    wr(5'd4, rnd_vec(), '1); rsv = 1; rsv_addr = 5'd4;
    cyc();
    set_idle();
    #1 chk("t4_rsvwin", VLEN'(busy[4]), VLEN'(1));
    chk("t4_noerr", VLEN'(rsv_err), VLEN'(0));

    // 5: bulk clear
    for (int a = 0; a < NR; a++) begin
      wr(AW'(a), rnd_vec(), '1);
      cyc();
    end
    set_idle(); rsv = 1; rsv_addr = 5'd9;
    cyc();
    set_idle(); clr = 1;
    cyc();
    lo = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      set_idle();
      if (i == 5) wr(5'd2, '1, '1);
      rsv = (i == 6); rsv_addr = 5'd3; clr = (i == 7);
      #1;
      if (!ready) lo++;
      if (clr_done) dn++;
      cyc();
    end
    chk("t5_lowcyc", VLEN'(lo), VLEN'(32));
    chk("t5_done1", VLEN'(dn), VLEN'(1));
    set_idle();
    #1 chk("t5_busy0", VLEN'(busy), '0);
    for (int a = 0; a < NR; a++) begin
      vs1_addr = AW'(a);
      #1 chk("t5_zero", vs1_data, '0);
      cyc();
    end

    // 6: reset in the middle of a clear
    wr(5'd31, {4{32'h12345678}}, '1);
    cyc();
    set_idle(); rsv = 1; rsv_addr = 5'd1;
    cyc();
    set_idle(); clr = 1;
    cyc();
    set_idle(); vs1_addr = 5'd31;
    repeat (10) cyc();
    #3 rst_n = 0;
    #1 m_reset();
    chk("t6_ready", VLEN'(ready), VLEN'(1));
    chk("t6_busy", VLEN'(busy), '0);
    chk("t6_v31", vs1_data, '0);
    chk("t6_nodone", VLEN'(clr_done), VLEN'(0));
    @(posedge clk);
    #3 rst_n = 1;
    repeat (40) cyc();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      we       = ($urandom_range(0, 1) == 1);
      vd_addr  = AW'($urandom());
      wdata    = rnd_vec();
      wbe      = ($urandom_range(0, 3) == 0) ? '1 : NB'($urandom());
      rsv      = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 7));
      clr      = ($urandom_range(0, 120) == 0);
      vs1_addr = ($urandom_range(0, 1) == 1) ? vd_addr : AW'($urandom());
      vs2_addr = ($urandom_range(0, 1) == 1) ? rsv_addr : AW'($urandom());
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
